// File: rtl/zprize_param.sv
// rtl/zprize_param.sv - shared parameters and types for the MSM point demux
package zprize_param;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_W     = 1152;
    localparam int unsigned CREDIT_MAX = 16;
    localparam int unsigned CREDIT_TH  = 2;

    typedef logic [$clog2(CREDIT_MAX + 1)-1:0] credit_t;

endpackage

// File: rtl/zprize_msm_credit_cnt.sv
// rtl/zprize_msm_credit_cnt.sv - per-core saturating credit counter
module zprize_msm_credit_cnt
    import zprize_param::*;
#(
    parameter int unsigned CMAX = CREDIT_MAX,
    parameter int unsigned CTH  = CREDIT_TH
) (
    input  logic clk,
    input  logic rstN,
    input  logic send,
    input  logic creditRet,
    output logic creditOk,
    output logic creditAvail,
    output logic underflow
);

    localparam int unsigned   CW     = $clog2(CMAX + 1);
    localparam logic [CW-1:0] CMAX_V = CW'(CMAX);
    localparam logic [CW-1:0] CTH_V  = CW'(CTH);

    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_d;

    // A send and a return in the same cycle cancel and never flag an error.
    always_comb begin
        credit_d  = credit_q;
        underflow = 1'b0;
        if (send && !creditRet) begin
            if (credit_q != '0) begin
                credit_d = credit_q - CW'(1);
            end
        end else if (creditRet && !send) begin
            if (credit_q == CMAX_V) begin
                underflow = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            credit_q <= CMAX_V;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign creditOk    = (credit_q >= CTH_V);
    assign creditAvail = (credit_q != '0);

endmodule

// File: rtl/zprize_msm_point_demux.sv
// rtl/zprize_msm_point_demux.sv - deals serialized point beats round-robin to cores
module zprize_msm_point_demux #(
    parameter int unsigned NUM_CH     = zprize_param::NUM_CH,
    parameter int unsigned DATA_W     = zprize_param::DATA_W,
    parameter int unsigned CREDIT_MAX = zprize_param::CREDIT_MAX,
    parameter int unsigned CREDIT_TH  = zprize_param::CREDIT_TH,
    localparam int unsigned SW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              pointPipeValid,
    input  logic [DATA_W-1:0] pointPipeData,
    input  logic [NUM_CH-1:0] creditReturn,
    output logic [NUM_CH-1:0] pointOutValid,
    output logic [DATA_W-1:0] pointOutData,
    output logic [NUM_CH-1:0] pointCreditOk,
    output logic              allCreditOk,
    output logic [SW-1:0]     switch,
    output logic              errOverflow,
    output logic              errUnderflow
);

    logic [SW-1:0]     switch_q, switch_d;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_udf_q, err_udf_d;

    logic [NUM_CH-1:0] send;
    logic [NUM_CH-1:0] avail;
    logic [NUM_CH-1:0] udf;
    logic              accept;
    logic              overflow;

    assign accept   = pointPipeValid && avail[switch_q];
    assign overflow = pointPipeValid && !avail[switch_q];

    // The pointer advances on every beat, dropped or not, to stay aligned with the mux.
    always_comb begin
        send      = '0;
        switch_d  = switch_q;
        data_d    = data_q;
        err_ovf_d = err_ovf_q | overflow;
        err_udf_d = err_udf_q | (|udf);
        if (accept) begin
            send[switch_q] = 1'b1;
            data_d         = pointPipeData;
        end
        if (pointPipeValid) begin
            switch_d = switch_q + SW'(1);
        end
        valid_d = send;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            switch_q  <= '0;
            valid_q   <= '0;
            data_q    <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            switch_q  <= switch_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        zprize_msm_credit_cnt #(
            .CMAX (CREDIT_MAX),
            .CTH  (CREDIT_TH)
        ) u_cnt (
            .clk         (clk),
            .rstN        (rstN),
            .send        (send[i]),
            .creditRet   (creditReturn[i]),
            .creditOk    (pointCreditOk[i]),
            .creditAvail (avail[i]),
            .underflow   (udf[i])
        );
    end

    assign pointOutValid = valid_q;
    assign pointOutData  = data_q;
    assign allCreditOk   = &pointCreditOk;
    assign switch        = switch_q;
    assign errOverflow   = err_ovf_q;
    assign errUnderflow  = err_udf_q;

endmodule

// File: tb/tb_zprize_msm_point_demux.sv
// tb/tb_zprize_msm_point_demux.sv - self-checking bench for the point demux
module tb_zprize_msm_point_demux;

    localparam int NCH  = 4;
    localparam int DW   = 1152;
    localparam int CMAX = 16;
    localparam int CTH  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstN;
    logic           pointPipeValid;
    logic [DW-1:0]  pointPipeData;
    logic [NCH-1:0] creditReturn;
    logic [NCH-1:0] pointOutValid;
    logic [DW-1:0]  pointOutData;
    logic [NCH-1:0] pointCreditOk;
    logic           allCreditOk;
    logic [1:0]     switch;
    logic           errOverflow;
    logic           errUnderflow;

    zprize_msm_point_demux dut (
        .clk            (clk),
        .rstN           (rstN),
        .pointPipeValid (pointPipeValid),
        .pointPipeData  (pointPipeData),
        .creditReturn   (creditReturn),
        .pointOutValid  (pointOutValid),
        .pointOutData   (pointOutData),
        .pointCreditOk  (pointCreditOk),
        .allCreditOk    (allCreditOk),
        .switch         (switch),
        .errOverflow    (errOverflow),
        .errUnderflow   (errUnderflow)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    int             m_credit [NCH];
    int             m_sw;
    logic [NCH-1:0] m_valid;
    logic [DW-1:0]  m_data;
    bit             m_ovf;
    bit             m_udf;

    function automatic logic [DW-1:0] beat(input int k);
        logic [31:0] w;
        w = 32'(k) * 32'h9E3779B1 + 32'h0000_1234;
        return {(DW/32){w}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_credit[i] = CMAX;
        m_sw    = 0;
        m_valid = '0;
        m_data  = '0;
        m_ovf   = 0;
        m_udf   = 0;
    endtask

    task automatic model_step(input bit v, input logic [DW-1:0] d, input logic [NCH-1:0] ret);
        int sent;
        sent    = -1;
        m_valid = '0;
        if (v) begin
            if (m_credit[m_sw] > 0) begin
                m_valid[m_sw] = 1'b1;
                m_data        = d;
                sent          = m_sw;
            end else begin
                m_ovf = 1;
            end
            m_sw = (m_sw + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            if (sent == i && ret[i]) begin
                // cancel
            end else if (sent == i) begin
                m_credit[i] = m_credit[i] - 1;
            end else if (ret[i]) begin
                if (m_credit[i] == CMAX) m_udf = 1;
                else m_credit[i] = m_credit[i] + 1;
            end
        end
    endtask

    // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
    task automatic step(input bit v, input logic [DW-1:0] d, input logic [NCH-1:0] ret, input bit rst);
        rstN           = !rst;
        pointPipeValid = v;
        pointPipeData  = d;
        creditReturn   = ret;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(v, d, ret);
        @(negedge clk);
    endtask

    task automatic beats(input int n, input int base);
        for (int i = 0; i < n; i++) step(1, beat(base + i), '0, 0);
        step(0, '0, '0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NCH-1:0] exp_ok;
            logic [DW-1:0]  ad;
            logic [DW-1:0]  ed;
            for (int i = 0; i < NCH; i++) exp_ok[i] = (m_credit[i] >= CTH);
            check("valid", 64'(pointOutValid), 64'(m_valid));
            n_checks++;
            if (pointOutData !== m_data) begin
                n_err++;
                ad = pointOutData;
                ed = m_data;
                $display("FAIL data: got %0h expected %0h at %0t", ad[63:0], ed[63:0], $time);
            end
            check("switch", 64'(switch), 64'(m_sw));
            check("creditOk", 64'(pointCreditOk), 64'(exp_ok));
            check("allCreditOk", 64'(allCreditOk), 64'(&exp_ok));
            check("errOverflow", 64'(errOverflow), 64'(m_ovf));
            check("errUnderflow", 64'(errUnderflow), 64'(m_udf));
            check("credit0", 64'(dut.g_ch[0].u_cnt.credit_q), 64'(m_credit[0]));
            check("credit1", 64'(dut.g_ch[1].u_cnt.credit_q), 64'(m_credit[1]));
            check("credit2", 64'(dut.g_ch[2].u_cnt.credit_q), 64'(m_credit[2]));
            check("credit3", 64'(dut.g_ch[3].u_cnt.credit_q), 64'(m_credit[3]));
        end
    end

    initial begin
        logic [DW-1:0]  t;
        logic [NCH-1:0] oh;

        rstN           = 1'b0;
        pointPipeValid = 1'b0;
        pointPipeData  = '0;
        creditReturn   = '0;
        @(negedge clk);
        step(0, '0, '0, 1);
        chk_en = 1;
        step(0, '0, '0, 1);

        check("rst_switch", 64'(switch), 64'd0);
        check("rst_valid", 64'(pointOutValid), 64'd0);
        t = pointOutData;
        check("rst_data", t[63:0], 64'd0);
        check("rst_creditOk", 64'(pointCreditOk), 64'hF);
        check("rst_allOk", 64'(allCreditOk), 64'd1);
        check("rst_errs", 64'({errOverflow, errUnderflow}), 64'd0);

        // 8 consecutive beats, one-hot walk 1,2,4,8,1,2,4,8
        for (int i = 0; i < 8; i++) begin
            step(1, beat(i), '0, 0);
            oh = 4'(1 << (i % 4));
            check("t1_onehot", 64'(pointOutValid), 64'(oh));
            t = beat(i);
            ad_check(t);
        end
        step(0, '0, '0, 0);
        check("t1_switch", 64'(switch), 64'd0);
        check("t1_model_credit0", 64'(m_credit[0]), 64'd14);
        check("t1_credit3", 64'(dut.g_ch[3].u_cnt.credit_q), 64'd14);
        check("t1_hold_valid", 64'(pointOutValid), 64'd0);

        // 15 beats per channel leaves one credit each
        step(0, '0, '0, 1);
        beats(60, 100);
        check("t2_creditOk", 64'(pointCreditOk), 64'd0);
        check("t2_allOk", 64'(allCreditOk), 64'd0);
        check("t2_credit0", 64'(dut.g_ch[0].u_cnt.credit_q), 64'd1);

        // drain to zero, then the next channel-0 beat overflows
        for (int i = 0; i < 4; i++) step(1, beat(200 + i), '0, 0);
        check("t3_no_ovf_yet", 64'(errOverflow), 64'd0);
        step(1, beat(300), '0, 0);
        check("t3_ovf", 64'(errOverflow), 64'd1);
        check("t3_novalid", 64'(pointOutValid), 64'd0);
        check("t3_switch", 64'(switch), 64'd1);
        step(0, '0, '0, 0);
        check("t3_sticky", 64'(errOverflow), 64'd1);

        // send and return on channel 2 at credit 10
        step(0, '0, '0, 1);
        beats(24, 400);
        step(1, beat(500), '0, 0);
        step(1, beat(501), '0, 0);
        step(1, beat(502), 4'b0100, 0);
        check("t4_valid2", 64'(pointOutValid), 64'b0100);
        check("t4_credit2", 64'(dut.g_ch[2].u_cnt.credit_q), 64'd10);
        check("t4_model_credit2", 64'(m_credit[2]), 64'd10);
        check("t4_errs", 64'({errOverflow, errUnderflow}), 64'd0);

        // three returns to channel 1 from 14
        step(0, '0, '0, 1);
        beats(8, 600);
        step(0, '0, 4'b0010, 0);
        check("t5_udf1", 64'(errUnderflow), 64'd0);
        step(0, '0, 4'b0010, 0);
        check("t5_udf2", 64'(errUnderflow), 64'd0);
        check("t5_sat", 64'(dut.g_ch[1].u_cnt.credit_q), 64'd16);
        step(0, '0, 4'b0010, 0);
        check("t5_udf3", 64'(errUnderflow), 64'd1);
        check("t5_stay", 64'(dut.g_ch[1].u_cnt.credit_q), 64'd16);

        // mid-stream reset with switch=3, credit1=5
        step(0, '0, '0, 1);
        step(0, '0, 4'b0100, 0);
        beats(43, 700);
        check("t6_pre_switch", 64'(switch), 64'd3);
        check("t6_pre_credit1", 64'(dut.g_ch[1].u_cnt.credit_q), 64'd5);
        check("t6_pre_udf", 64'(errUnderflow), 64'd1);
        step(1, beat(800), 4'b0110, 1);
        check("t6_switch", 64'(switch), 64'd0);
        check("t6_valid", 64'(pointOutValid), 64'd0);
        t = pointOutData;
        check("t6_data", t[63:0], 64'd0);
        check("t6_creditOk", 64'(pointCreditOk), 64'hF);
        check("t6_credit1", 64'(dut.g_ch[1].u_cnt.credit_q), 64'd16);
        check("t6_errs", 64'({errOverflow, errUnderflow}), 64'd0);
        step(1, beat(801), '0, 0);
        check("t6_next_ch0", 64'(pointOutValid), 64'b0001);
        t = beat(801);
        ad_check(t);
        step(0, '0, '0, 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    task automatic ad_check(input logic [DW-1:0] exp);
        n_checks++;
        if (pointOutData !== exp) begin
            logic [DW-1:0] a;
            a = pointOutData;
            n_err++;
            $display("FAIL beat_data: got %0h expected %0h at %0t", a[63:0], exp[63:0], $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

endmodule
